// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle main FSM and the datapath.
// The FSM side drives every enable; the datapath returns opcode and mem_ready.
interface mc_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       pc_source;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [3:0]       state;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source,
    output iord, mem_read, mem_write, ir_write,
    output reg_dst, mem_to_reg, reg_write,
    output alu_src_a, alu_src_b, alu_op,
    output state, illegal_op, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source,
    input  iord, mem_read, mem_write, ir_write,
    input  reg_dst, mem_to_reg, reg_write,
    input  alu_src_a, alu_src_b, alu_op,
    input  state, illegal_op, retired
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control: fetch/decode/execute/mem/writeback
// sequencing over one shared memory port and one shared ALU.
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  mc_control_fsm_if.master    bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    retire             = 1'b0;
    bus.pc_write       = 1'b0;
    bus.pc_write_cond  = 1'b0;
    bus.pc_source      = 2'b00;
    bus.iord           = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.ir_write       = 1'b0;
    bus.reg_dst        = 1'b0;
    bus.mem_to_reg     = 1'b0;
    bus.reg_write      = 1'b0;
    bus.alu_src_a      = 1'b0;
    bus.alu_src_b      = 2'b00;
    bus.alu_op         = 2'b00;
    bus.illegal_op     = 1'b0;
    unique case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        // Reset must not let a stale mem_ready load IR or PC.
        bus.ir_write  = bus.mem_ready & ~rst;
        bus.pc_write  = bus.mem_ready & ~rst;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        unique case (bus.opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_ADDI:      state_d = ADDI_EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          default: begin
            state_d        = FETCH;
            bus.illegal_op = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d = (bus.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        retire         = 1'b1;
        state_d        = FETCH;
      end
      MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      EXECUTE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = ALU_WB;
      end
      ALU_WB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
        retire        = 1'b1;
        state_d       = FETCH;
      end
      ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = ADDI_WB;
      end
      ADDI_WB: begin
        bus.reg_write = 1'b1;
        retire        = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        retire            = 1'b1;
        state_d           = FETCH;
      end
      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        retire        = 1'b1;
        state_d       = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign retired_d   = retired_q + CNT_W'(retire);
  assign bus.state   = state_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: table-driven instruction vectors, hand-built
// reset/wait/wrap sequences and a randomized run against a queue model.
module tb_mc_control_fsm;

  localparam int CW = 4;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } out_t;

  typedef struct {
    logic [5:0] op;
    int         ncyc;
    int         seq[6];
    int         dret;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_control_fsm_if #(.CNT_W(CW)) bus();

  mc_control_fsm #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int errors = 0;

  out_t         tab[12];
  int           m_st;
  int           q[$];
  logic [CW-1:0] m_ret;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000,
                      6'b001000, 6'b000100, 6'b000010};
  endfunction

  task automatic route(input logic [5:0] op);
    case (op)
      6'b100011: q = '{2, 3, 4};
      6'b101011: q = '{2, 5};
      6'b000000: q = '{6, 7};
      6'b001000: q = '{10, 11};
      6'b000100: q = '{8};
      6'b000010: q = '{9};
      default:   q = {};
    endcase
  endtask

  function automatic out_t act_out();
    out_t o;
    o.pc_write      = bus.pc_write;
    o.pc_write_cond = bus.pc_write_cond;
    o.pc_source     = bus.pc_source;
    o.iord          = bus.iord;
    o.mem_read      = bus.mem_read;
    o.mem_write     = bus.mem_write;
    o.ir_write      = bus.ir_write;
    o.reg_dst       = bus.reg_dst;
    o.mem_to_reg    = bus.mem_to_reg;
    o.reg_write     = bus.reg_write;
    o.alu_src_a     = bus.alu_src_a;
    o.alu_src_b     = bus.alu_src_b;
    o.alu_op        = bus.alu_op;
    return o;
  endfunction

  task automatic model_reset();
    m_st  = 0;
    m_ret = '0;
    q     = {};
  endtask

  // One clock cycle: drive at negedge, check, then advance the model.
  task automatic cyc(input logic [5:0] op, input logic mr, input logic r,
                     output int st, output logic ill);
    out_t e;
    int   nx;
    @(negedge clk);
    rst = r;
    bus.opcode = op;
    bus.mem_ready = mr;
    #1;
    if (r) model_reset();
    e = tab[m_st];
    if (m_st == 0 && mr && !r) begin
      e.ir_write = 1'b1;
      e.pc_write = 1'b1;
    end
    chk("state", 32'(bus.state), 32'(m_st));
    chk("outputs", 32'(act_out()), 32'(e));
    chk("illegal_op", 32'(bus.illegal_op),
        32'(m_st == 1 && !legal(op)));
    chk("retired", 32'(bus.retired), 32'(m_ret));
    st  = int'(bus.state);
    ill = bus.illegal_op;
    if (!r) begin
      if (m_st == 0) nx = mr ? 1 : 0;
      else if ((m_st == 3 || m_st == 5) && !mr) nx = m_st;
      else begin
        if (m_st == 1) route(op);
        nx = (q.size() > 0) ? q.pop_front() : 0;
        if (nx == 0 && m_st != 1) m_ret++;
      end
      m_st = nx;
    end
  endtask

  vec_t vecs[7];

  initial begin
    int st;
    logic ill;
    int ncy;
    int nill;
    logic [CW-1:0] r0;
    logic [5:0] rop;
    logic [5:0] ops[7];

    tab[0]  = '{mem_read:1'b1, alu_src_b:2'b01, default:'0};
    tab[1]  = '{alu_src_b:2'b11, default:'0};
    tab[2]  = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
    tab[3]  = '{mem_read:1'b1, iord:1'b1, default:'0};
    tab[4]  = '{mem_to_reg:1'b1, reg_write:1'b1, default:'0};
    tab[5]  = '{mem_write:1'b1, iord:1'b1, default:'0};
    tab[6]  = '{alu_src_a:1'b1, alu_op:2'b10, default:'0};
    tab[7]  = '{reg_dst:1'b1, reg_write:1'b1, default:'0};
    tab[8]  = '{alu_src_a:1'b1, alu_op:2'b01, pc_write_cond:1'b1,
                pc_source:2'b01, default:'0};
    tab[9]  = '{pc_write:1'b1, pc_source:2'b10, default:'0};
    tab[10] = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
    tab[11] = '{reg_write:1'b1, default:'0};

    vecs[0] = '{6'b000000, 4, '{0, 1, 6, 7, 0, 0}, 1};
    vecs[1] = '{6'b001000, 4, '{0, 1, 10, 11, 0, 0}, 1};
    vecs[2] = '{6'b100011, 5, '{0, 1, 2, 3, 4, 0}, 1};
    vecs[3] = '{6'b101011, 4, '{0, 1, 2, 5, 0, 0}, 1};
    vecs[4] = '{6'b000100, 3, '{0, 1, 8, 0, 0, 0}, 1};
    vecs[5] = '{6'b000010, 3, '{0, 1, 9, 0, 0, 0}, 1};
    vecs[6] = '{6'b111111, 2, '{0, 1, 0, 0, 0, 0}, 0};

    bus.opcode = '0;
    bus.mem_ready = 1'b1;
    model_reset();
    repeat (2) cyc(6'h00, 1'b1, 1'b1, st, ill);

    // Table: each instruction with mem_ready high.
    foreach (vecs[k]) begin
      r0 = bus.retired;
      nill = 0;
      for (int c = 0; c < vecs[k].ncyc; c++) begin
        cyc(vecs[k].op, 1'b1, 1'b0, st, ill);
        chk($sformatf("vec%0d_state%0d", k, c), 32'(st),
            32'(vecs[k].seq[c]));
        nill += int'(ill);
      end
      @(posedge clk); #1;
      chk($sformatf("vec%0d_back_in_fetch", k), 32'(bus.state), 32'd0);
      chk($sformatf("vec%0d_retired", k), 32'(bus.retired),
          32'(r0 + CW'(vecs[k].dret)));
      chk($sformatf("vec%0d_illegal_pulses", k), 32'(nill),
          32'(vecs[k].dret == 0));
    end

    // lw with 2 FETCH waits and 3 MEM_READ waits: 10 cycles.
    r0 = bus.retired;
    ncy = 0;
    repeat (2) begin cyc(6'b100011, 1'b0, 1'b0, st, ill); ncy++; end
    cyc(6'b100011, 1'b1, 1'b0, st, ill); ncy++;
    cyc(6'b100011, 1'b0, 1'b0, st, ill); ncy++;
    cyc(6'b100011, 1'b0, 1'b0, st, ill); ncy++;
    repeat (3) begin
      cyc(6'b100011, 1'b0, 1'b0, st, ill); ncy++;
      chk("lw_wait_memread", 32'({bus.mem_read, bus.iord}), 32'd3);
    end
    cyc(6'b100011, 1'b1, 1'b0, st, ill); ncy++;
    cyc(6'b100011, 1'b1, 1'b0, st, ill); ncy++;
    chk("lw_wb", 32'({bus.mem_to_reg, bus.reg_write}), 32'd3);
    @(posedge clk); #1;
    chk("lw_total_cycles", 32'(ncy), 32'd10);
    chk("lw_end_state", 32'(bus.state), 32'd0);
    chk("lw_retired", 32'(bus.retired), 32'(r0 + CW'(1)));

    // Asynchronous reset in the middle of a MEM_READ wait.
    cyc(6'b100011, 1'b1, 1'b0, st, ill);
    cyc(6'b100011, 1'b1, 1'b0, st, ill);
    cyc(6'b100011, 1'b1, 1'b0, st, ill);
    cyc(6'b100011, 1'b0, 1'b0, st, ill);
    chk("pre_reset_memread", 32'(st), 32'd3);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_state", 32'(bus.state), 32'd0);
    chk("async_rst_retired", 32'(bus.retired), 32'd0);
    chk("async_rst_ir_pc", 32'({bus.ir_write, bus.pc_write}), 32'd0);
    chk("async_rst_statics", 32'({bus.mem_read, bus.alu_src_b}), 32'd5);
    cyc(6'b100011, 1'b1, 1'b1, st, ill);
    cyc(6'b100011, 1'b1, 1'b0, st, ill);
    chk("post_rst_ir_pc", 32'({bus.ir_write, bus.pc_write}), 32'd3);

    // Retired counter wraps through 16 addi instructions.
    cyc(6'h00, 1'b1, 1'b1, st, ill);
    for (int i = 0; i < 16; i++) begin
      repeat (4) cyc(6'b001000, 1'b1, 1'b0, st, ill);
      if (i == 14) begin
        @(posedge clk); #1;
        chk("wrap_at_15", 32'(bus.retired), 32'd15);
      end
    end
    @(posedge clk); #1;
    chk("wrap_to_0", 32'(bus.retired), 32'd0);

    // Randomized run; opcode held steady from DECODE through MEM_ADDR.
    ops = '{6'b000000, 6'b001000, 6'b100011, 6'b101011,
            6'b000100, 6'b000010, 6'b111111};
    rop = ops[0];
    for (int n = 0; n < 600; n++) begin
      if (m_st != 2) begin
        rop = ops[$urandom_range(0, 6)];
        if ($urandom_range(0, 9) == 0) rop = 6'($urandom);
      end
      cyc(rop, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0),
          st, ill);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
